rob_ring_buffer: RTL and testbench

- Parametrised in-order reorder buffer queue; successor to the single-port ROB FIFO.
- Allocates one entry per cycle at the tail and returns its index to dispatch.
- Accepts out-of-order completion writes by index.
- Retires up to RETIRE_WIDTH consecutive completed entries per cycle from the head; supports full pipeline flush.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_retire_select.sv | 37 +++
 rtl/rob_ring_buffer.sv | 125 ++++++++++++
 tb/tb_rob_ring_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants, per-entry status type and ring-index helper for the reorder buffer.
package rob_pkg;

    localparam int ROB_DEPTH        = 16;
    localparam int ROB_RETIRE_WIDTH = 2;
    localparam int ROB_DATA_WIDTH   = 32;
    localparam int ROB_RES_WIDTH    = 32;

    typedef struct packed {
        logic valid;
        logic done;
    } rob_status_t;

    // Depth is a power of two, so wrapping is a mask rather than a modulo.
    function automatic int unsigned rob_idx_add(input int unsigned base,
                                                input int unsigned off,
                                                input int unsigned depth);
        return (base + off) & (depth - 1);
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Combinational choice of the contiguous run of completed entries at the head.
module rob_retire_select
    import rob_pkg::*;
#(
    parameter int DEPTH        = ROB_DEPTH,
    parameter int RETIRE_WIDTH = ROB_RETIRE_WIDTH,
    parameter int IDX_W        = $clog2(DEPTH)
) (
    input  logic [IDX_W:0]          head,
    input  logic [IDX_W:0]          count,
    input  logic [DEPTH-1:0]        done,
    input  logic                    stall,
    input  logic                    flush,
    output logic [RETIRE_WIDTH-1:0] retire_valid,
    output logic [IDX_W:0]          retire_cnt
);

    logic             chain;
    logic [IDX_W-1:0] idx;

    // The chain breaks at the first slot that is empty or not done, keeping retirement in order.
    always_comb begin
        retire_valid = '0;
        retire_cnt   = '0;
        idx          = '0;
        chain        = !stall && !flush;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            idx   = IDX_W'(rob_idx_add(int'(head[IDX_W-1:0]), k, DEPTH));
            chain = chain && ((IDX_W+1)'(k) < count) && done[idx];
            retire_valid[k] = chain;
            if (chain) begin
                retire_cnt = retire_cnt + (IDX_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rob_ring_buffer.sv
// In-order reorder buffer: allocate at tail, complete by index, retire a contiguous run from head.
module rob_ring_buffer
    import rob_pkg::*;
#(
    parameter  int DATA_WIDTH   = ROB_DATA_WIDTH,
    parameter  int RES_WIDTH    = ROB_RES_WIDTH,
    parameter  int DEPTH        = ROB_DEPTH,
    parameter  int RETIRE_WIDTH = ROB_RETIRE_WIDTH,
    localparam int IDX_W        = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [DATA_WIDTH-1:0]             alloc_data,
    output logic [IDX_W-1:0]                  alloc_idx,
    input  logic                              cpl_valid,
    input  logic [IDX_W-1:0]                  cpl_idx,
    input  logic [RES_WIDTH-1:0]              cpl_result,
    input  logic                              retire_stall,
    output logic [RETIRE_WIDTH-1:0]           retire_valid,
    output logic [RETIRE_WIDTH*DATA_WIDTH-1:0] retire_data,
    output logic [RETIRE_WIDTH*RES_WIDTH-1:0]  retire_result,
    input  logic                              flush,
    output logic [IDX_W:0]                    count,
    output logic                              full,
    output logic                              empty
);

    logic [IDX_W:0]         head;
    logic [IDX_W:0]         tail;
    rob_status_t            status  [DEPTH];
    logic [DATA_WIDTH-1:0]  payload [DEPTH];
    logic [RES_WIDTH-1:0]   result  [DEPTH];
    logic [DEPTH-1:0]       done_vec;
    logic [IDX_W:0]         retire_cnt;
    logic [IDX_W-1:0]       slot_idx [RETIRE_WIDTH];
    logic                   alloc_fire;
    logic                   cpl_fire;

    assign count       = tail - head;
    assign full        = (count == (IDX_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_idx   = tail[IDX_W-1:0];

    // Allocation handshake: an entry is taken on a clock edge where alloc_valid && alloc_ready,
    // alloc_ready depends only on registered pointers, and flush cancels the transfer.
    assign alloc_ready = !full;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign cpl_fire    = cpl_valid && status[cpl_idx].valid && !flush;

    always_comb begin
        done_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            done_vec[i] = status[i].done;
        end
    end

    rob_retire_select #(
        .DEPTH        (DEPTH),
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .IDX_W        (IDX_W)
    ) u_retire_select (
        .head         (head),
        .count        (count),
        .done         (done_vec),
        .stall        (retire_stall),
        .flush        (flush),
        .retire_valid (retire_valid),
        .retire_cnt   (retire_cnt)
    );

    always_comb begin
        retire_data   = '0;
        retire_result = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            slot_idx[k] = IDX_W'(rob_idx_add(int'(head[IDX_W-1:0]), k, DEPTH));
            if (retire_valid[k]) begin
                retire_data[k*DATA_WIDTH +: DATA_WIDTH] = payload[slot_idx[k]];
                retire_result[k*RES_WIDTH +: RES_WIDTH] = result[slot_idx[k]];
            end
        end
    end

    // Retire, allocate and complete never target the same entry in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                status[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                status[i] <= '0;
            end
        end else begin
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (retire_valid[k]) begin
                    status[slot_idx[k]] <= '0;
                end
            end
            if (alloc_fire) begin
                status[alloc_idx] <= '{valid: 1'b1, done: 1'b0};
                tail              <= tail + (IDX_W+1)'(1);
            end
            if (cpl_fire) begin
                status[cpl_idx].done <= 1'b1;
            end
            head <= head + retire_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            payload[alloc_idx] <= alloc_data;
        end
        if (cpl_fire) begin
            result[cpl_idx] <= cpl_result;
        end
    end

endmodule

// File: tb/tb_rob_ring_buffer.sv
// Directed bench for rob_ring_buffer: driver tasks feed a reference queue, a monitor checks retirements.
module tb_rob_ring_buffer;
    import rob_pkg::*;

    localparam int DW = 32;
    localparam int RS = 32;
    localparam int D  = 16;
    localparam int RW = 2;
    localparam int IW = 4;

    logic              clk;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [DW-1:0]     alloc_data;
    logic [IW-1:0]     alloc_idx;
    logic              cpl_valid;
    logic [IW-1:0]     cpl_idx;
    logic [RS-1:0]     cpl_result;
    logic              retire_stall;
    logic [RW-1:0]     retire_valid;
    logic [RW*DW-1:0]  retire_data;
    logic [RW*RS-1:0]  retire_result;
    logic              flush;
    logic [IW:0]       count;
    logic              full;
    logic              empty;

    rob_ring_buffer #(
        .DATA_WIDTH   (DW),
        .RES_WIDTH    (RS),
        .DEPTH        (D),
        .RETIRE_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_data    (alloc_data),
        .alloc_idx     (alloc_idx),
        .cpl_valid     (cpl_valid),
        .cpl_idx       (cpl_idx),
        .cpl_result    (cpl_result),
        .retire_stall  (retire_stall),
        .retire_valid  (retire_valid),
        .retire_data   (retire_data),
        .retire_result (retire_result),
        .flush         (flush),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    logic [IW-1:0] exp_q[$];
    logic [DW-1:0] m_payload [D];
    logic [RS-1:0] m_result  [D];
    bit            m_valid   [D];
    int            m_tail;
    int            m_retired;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_tail    = 0;
        m_retired = 0;
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
    endtask

    // One clock cycle of stimulus; inputs return to idle afterwards.
    task automatic drive(input logic av, input logic [DW-1:0] ad, input logic cv,
                         input logic [IW-1:0] ci, input logic [RS-1:0] cr,
                         input logic st, input logic fl);
        int slot;
        alloc_valid  = av;
        alloc_data   = ad;
        cpl_valid    = cv;
        cpl_idx      = ci;
        cpl_result   = cr;
        retire_stall = st;
        flush        = fl;
        #2;
        slot = m_tail % D;
        chk("alloc_idx", 64'(alloc_idx), 64'(slot));
        chk("alloc_ready", 64'(alloc_ready), 64'((m_tail - m_retired) < D));
        if (fl) begin
            model_clear();
        end else begin
            if (cv && m_valid[ci]) m_result[ci] = cr;
            if (av && (m_tail - m_retired) < D) begin
                exp_q.push_back(IW'(slot));
                m_payload[slot] = ad;
                m_valid[slot]   = 1'b1;
                m_tail++;
            end
        end
        @(posedge clk);
        #1;
        alloc_valid  = 1'b0;
        alloc_data   = '0;
        cpl_valid    = 1'b0;
        cpl_idx      = '0;
        cpl_result   = '0;
        retire_stall = 1'b0;
        flush        = 1'b0;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every retiring slot must match the oldest outstanding allocation.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] d;
        logic [RS-1:0] r;
        logic [IW-1:0] idx;
        if (!rst) begin
            for (int k = 0; k < RW; k++) begin
                d = retire_data[k*DW +: DW];
                r = retire_result[k*RS +: RS];
                if (retire_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL retire_unexpected slot %0d: got data %0h expected no retirement", k, d);
                    end else begin
                        idx = exp_q.pop_front();
                        chk("retire_data", 64'(d), 64'(m_payload[idx]));
                        chk("retire_result", 64'(r), 64'(m_result[idx]));
                        m_valid[idx] = 1'b0;
                        m_retired++;
                    end
                end else begin
                    chk("retire_zero", {d, r}, 64'd0);
                end
            end
        end
    end

    logic [IW-1:0] wrap_idx [4];

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        alloc_valid  = 1'b0;
        alloc_data   = '0;
        cpl_valid    = 1'b0;
        cpl_idx      = '0;
        cpl_result   = '0;
        retire_stall = 1'b0;
        flush        = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_retire_data", 64'(retire_data), 64'd0);
        chk("rst_retire_result", 64'(retire_result), 64'd0);

        // Fill to full, then a dropped request
        for (int i = 0; i < 16; i++) drive(1'b1, 32'hD100_0000 + 32'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(alloc_ready), 64'd0);
        chk("fill_count", 64'(count), 64'd16);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop_count", 64'(count), 64'd16);
        chk("drop_alloc_idx", 64'(alloc_idx), 64'd0);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("flush1_count", 64'(count), 64'd0);
        chk("flush1_empty", 64'(empty), 64'd1);

        // Out-of-order completion, in-order retirement
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hD200_0000 + 32'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd2, 32'hC200_0002, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd3, 32'hC200_0003, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd0, 32'hC200_0000, 1'b0, 1'b0);
        chk("ooo_rv_a", 64'(retire_valid), 64'b01);
        drive(1'b0, '0, 1'b1, 4'd1, 32'hC200_0001, 1'b0, 1'b0);
        chk("ooo_rv_b", 64'(retire_valid), 64'b11);
        idle();
        chk("ooo_rv_c", 64'(retire_valid), 64'b01);
        idle();
        chk("ooo_empty", 64'(empty), 64'd1);
        chk("ooo_count", 64'(count), 64'd0);

        // Advance head to 14, then wrap
        for (int i = 0; i < 10; i++)
            drive(1'b1, 32'hD300_0000 + 32'(i), i > 0, IW'(3 + i), 32'hC300_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd13, 32'hC300_000D, 1'b0, 1'b0);
        repeat (6) idle();
        chk("pre_wrap_count", 64'(count), 64'd0);
        chk("pre_wrap_idx", 64'(alloc_idx), 64'd14);
        wrap_idx[0] = 4'd14;
        wrap_idx[1] = 4'd15;
        wrap_idx[2] = 4'd0;
        wrap_idx[3] = 4'd1;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hD400_0000 + 32'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("wrap_count4", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            drive(1'b0, '0, 1'b1, wrap_idx[i], 32'hC400_0000 + 32'(i), 1'b1, 1'b0);
        chk("wrap_rv_a", 64'(retire_valid), 64'b11);
        idle();
        chk("wrap_rv_b", 64'(retire_valid), 64'b11);
        chk("wrap_count2", 64'(count), 64'd2);
        idle();
        chk("wrap_count0", 64'(count), 64'd0);
        chk("wrap_empty", 64'(empty), 64'd1);
        chk("wrap_alloc_idx", 64'(alloc_idx), 64'd2);

        // Retire stall held three cycles
        drive(1'b1, 32'hD500_0000, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'hD500_0001, 1'b1, 4'd2, 32'hC500_0002, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 4'd3, 32'hC500_0003, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            retire_stall = 1'b1;
            #2;
            chk("stall_rv", 64'(retire_valid), 64'd0);
            chk("stall_count", 64'(count), 64'd2);
            @(posedge clk);
            #1;
        end
        retire_stall = 1'b0;
        #1;
        chk("unstall_rv", 64'(retire_valid), 64'b11);
        idle();
        chk("unstall_empty", 64'(empty), 64'd1);

        // Flush with alloc and completion pending
        for (int i = 0; i < 10; i++) drive(1'b1, 32'hD600_0000 + 32'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd10);
        drive(1'b1, 32'hD600_00FF, 1'b1, 4'd5, 32'hC600_00FF, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_alloc_idx", 64'(alloc_idx), 64'd0);
        drive(1'b0, '0, 1'b1, 4'd5, 32'hC600_0055, 1'b0, 1'b0);
        chk("stale_count", 64'(count), 64'd0);
        chk("stale_rv", 64'(retire_valid), 64'd0);

        // Full with head done: retire but no allocation, then allocate at old head
        for (int i = 0; i < 16; i++) drive(1'b1, 32'hD700_0000 + 32'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("full2", 64'(full), 64'd1);
        drive(1'b0, '0, 1'b1, 4'd0, 32'hC700_0000, 1'b1, 1'b0);
        chk("full_rv", 64'(retire_valid), 64'b01);
        chk("full_still", 64'(full), 64'd1);
        drive(1'b1, 32'hD700_00AA, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("full_retire_count", 64'(count), 64'd15);
        chk("full_retire_full", 64'(full), 64'd0);
        chk("full_retire_idx", 64'(alloc_idx), 64'd0);
        drive(1'b1, 32'hD700_00BB, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("refill_count", 64'(count), 64'd16);
        chk("refill_full", 64'(full), 64'd1);

        // Asynchronous reset mid-cycle
        rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_idx", 64'(alloc_idx), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_rv", 64'(retire_valid), 64'd0);
        chk("post_rst_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
